// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: RAM control pin positions,
// FSM state encoding and the latched transaction record.
package ram_arbiter_pkg;

  // Bit positions within ram_ctrl_to_hw / ram_ctrl_from_hw
  localparam int RAM_READ_PIN  = 0;
  localparam int RAM_WRITE_PIN = 1;
  localparam int RAM_READY_PIN = 0;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_DONE  = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } txn_t;

  function automatic logic [31:0] ctrl_word(input logic rd, input logic wr);
    logic [31:0] w;
    w                = '0;
    w[RAM_READ_PIN]  = rd;
    w[RAM_WRITE_PIN] = wr;
    return w;
  endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Requester handshakes and RAM bus of the arbiter. The slave modport is the
// arbiter's view; master is the view of whatever drives the requests and RAM.
interface ram_arbiter_if;

  logic        req0;
  logic        we0;
  logic [31:0] addr0;
  logic [31:0] wdata0;
  logic        gnt0;
  logic        done0;

  logic        req1;
  logic        we1;
  logic [31:0] addr1;
  logic [31:0] wdata1;
  logic        gnt1;
  logic        done1;

  logic [31:0] rdata;
  logic        busy;
  logic        err;

  logic [31:0] ram_ctrl_from_hw;
  logic [31:0] ram_ctrl_to_hw;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic [31:0] data_out;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_ctrl_from_hw, data_in,
    input  gnt0, done0, gnt1, done1,
    input  rdata, busy, err,
    input  ram_ctrl_to_hw, addr, data_out
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_ctrl_from_hw, data_in,
    output gnt0, done0, gnt1, done1,
    output rdata, busy, err,
    output ram_ctrl_to_hw, addr, data_out
  );

endinterface

// File: rtl/ram_arbiter_arb_pick.sv
// Combinational port selection for the arbiter: round-robin against the last
// granted port, or fixed priority with port 0 winning when RR_EN is 0.
module arb_pick #(
  parameter bit RR_EN = 1'b1
) (
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_grant_i,
  output logic valid_o,
  output logic sel_o
);

  always_comb begin
    valid_o = req0_i | req1_i;
    sel_o   = 1'b0;
    if (req0_i && req1_i) begin
      sel_o = RR_EN ? ~last_grant_i : 1'b0;
    end else if (req1_i) begin
      sel_o = 1'b1;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port RAM arbiter: one transaction at a time, req/gnt/done handshake,
// registered outputs. Optional ISSUE timeout enabled by RAM_ARB_TIMEOUT_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter bit          RR_EN    = 1'b1,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic          clk,
  input  logic          rst,
  ram_arbiter_if.slave  bus
);

  arb_state_e  state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic        port_q, port_d;
  txn_t        txn_q, txn_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] ctrl_q, ctrl_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] data_out_q, data_out_d;
`ifdef RAM_ARB_TIMEOUT_EN
  logic [7:0]  wait_q, wait_d;
`endif

  logic        pick_valid;
  logic        pick_sel;
  logic        ready;
  logic        pins_on;
  logic        finish;
  txn_t        sel_txn;
  logic        unused_bits;

  arb_pick #(
    .RR_EN (RR_EN)
  ) u_pick (
    .req0_i       (bus.req0),
    .req1_i       (bus.req1),
    .last_grant_i (last_grant_q),
    .valid_o      (pick_valid),
    .sel_o        (pick_sel)
  );

  assign ready       = bus.ram_ctrl_from_hw[RAM_READY_PIN];
  assign pins_on     = ctrl_q[RAM_READ_PIN] | ctrl_q[RAM_WRITE_PIN];
  assign unused_bits = ^{bus.ram_ctrl_from_hw, 32'(MAX_WAIT)};

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    port_d       = port_q;
    txn_d        = txn_q;
    gnt0_d       = 1'b0;
    gnt1_d       = 1'b0;
    done0_d      = 1'b0;
    done1_d      = 1'b0;
    err_d        = 1'b0;
    rdata_d      = rdata_q;
    ctrl_d       = '0;
    addr_d       = addr_q;
    data_out_d   = data_out_q;
    finish       = 1'b0;
`ifdef RAM_ARB_TIMEOUT_EN
    wait_d       = wait_q;
`endif
    sel_txn = pick_sel ? {bus.we1, bus.addr1, bus.wdata1}
                       : {bus.we0, bus.addr0, bus.wdata0};

    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          port_d       = pick_sel;
          last_grant_d = pick_sel;
          txn_d        = sel_txn;
          gnt0_d       = ~pick_sel;
          gnt1_d       = pick_sel;
          addr_d       = sel_txn.addr;
          if (sel_txn.we) begin
            data_out_d = sel_txn.wdata;
          end
          state_d      = ARB_ISSUE;
`ifdef RAM_ARB_TIMEOUT_EN
          wait_d       = '0;
`endif
        end
      end

      // First ISSUE cycle only raises the pins; ready is honoured once
      // the pins are actually on the bus.
      ARB_ISSUE: begin
        ctrl_d = ctrl_word(~txn_q.we, txn_q.we);
        if (pins_on && ready) begin
          if (!txn_q.we) begin
            rdata_d = bus.data_in;
          end
          finish = 1'b1;
        end
`ifdef RAM_ARB_TIMEOUT_EN
        else if (!ready) begin
          wait_d = wait_q + 8'd1;
          if (wait_q == 8'(MAX_WAIT - 1)) begin
            finish = 1'b1;
            err_d  = 1'b1;
          end
        end
`endif
      end

      ARB_DONE: begin
        state_d = ARB_IDLE;
      end

      default: begin
        state_d = ARB_IDLE;
      end
    endcase

    if (finish) begin
      state_d = ARB_DONE;
      ctrl_d  = '0;
      done0_d = ~port_q;
      done1_d = port_q;
    end

    busy_d = (state_d != ARB_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= 1'b1;
      port_q       <= 1'b0;
      txn_q        <= '0;
      gnt0_q       <= 1'b0;
      gnt1_q       <= 1'b0;
      done0_q      <= 1'b0;
      done1_q      <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      ctrl_q       <= '0;
      addr_q       <= '0;
      data_out_q   <= '0;
`ifdef RAM_ARB_TIMEOUT_EN
      wait_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      port_q       <= port_d;
      txn_q        <= txn_d;
      gnt0_q       <= gnt0_d;
      gnt1_q       <= gnt1_d;
      done0_q      <= done0_d;
      done1_q      <= done1_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      rdata_q      <= rdata_d;
      ctrl_q       <= ctrl_d;
      addr_q       <= addr_d;
      data_out_q   <= data_out_d;
`ifdef RAM_ARB_TIMEOUT_EN
      wait_q       <= wait_d;
`endif
    end
  end

  assign bus.gnt0           = gnt0_q;
  assign bus.gnt1           = gnt1_q;
  assign bus.done0          = done0_q;
  assign bus.done1          = done1_q;
  assign bus.busy           = busy_q;
  assign bus.err            = err_q;
  assign bus.rdata          = rdata_q;
  assign bus.ram_ctrl_to_hw = ctrl_q;
  assign bus.addr           = addr_q;
  assign bus.data_out       = data_out_q;

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
- Shares the single mobo RAM bus (ram_ctrl_to_hw/ram_ctrl_from_hw, addr, data_in, data_out) between two requesters: port 0 (CPU/AM path) and port 1 (VGA fetch).
- Sequences one RAM transaction at a time with a req/gnt/done handshake.
- Drives the RAM read/write control pins, then waits for the RAM ready pin.
- Instantiated inside mobo in place of its direct state-driven RAM access.

Parameters:
- RR_EN, 1, 1 = round-robin arbitration; 0 = fixed priority, port 0 wins.
- MAX_WAIT, 255, cycles in ISSUE before timeout. Used only with the optional feature; 8-bit counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  port 0 request; held until done0.
- we0  in  1  port 0: 1 = write, 0 = read.
- addr0  in  32  port 0 address.
- wdata0  in  32  port 0 write data.
- gnt0  out  1  one-cycle pulse: port 0 accepted.
- done0  out  1  one-cycle pulse: port 0 transaction finished.
- req1, we1, addr1, wdata1, gnt1, done1  same as port 0, for port 1.
- rdata  out  32  read data, valid in the done cycle, held until the next read completes.
- busy  out  1  high in ISSUE and DONE.
- err  out  1  one-cycle pulse with done on timeout; tied 0 without the optional feature.
- ram_ctrl_from_hw  in  32  RAM status; bit `RAM_READY_PIN used.
- ram_ctrl_to_hw  out  32  RAM control; bits `RAM_READ_PIN and `RAM_WRITE_PIN driven, all others 0.
- addr  out  32  RAM address.
- data_in  in  32  RAM read data.
- data_out  out  32  RAM write data.

Behaviour:
- All outputs are registered. On reset all outputs are 0, state = IDLE, and last_grant = 1 (port 0 is favoured first).
- Reset mid-transaction aborts immediately: control pins drop to 0 and no done is issued.
- States are IDLE, ISSUE and DONE.
- IDLE:
  - Sample req0/req1 each cycle.
  - If only one request is high, select that port.
  - If both are high and RR_EN = 1, select the port != last_grant; if RR_EN = 0, select port 0.
  - On selection: latch the port's we/addr/wdata, pulse its gnt for 1 cycle, update last_grant, go to ISSUE.
- ISSUE:
  - addr = latched addr.
  - On a write, data_out = latched wdata and `RAM_WRITE_PIN = 1; on a read, `RAM_READ_PIN = 1.
  - Read and write pins are never high together.
  - When `RAM_READY_PIN is sampled 1: on a read, capture data_in into rdata; go to DONE.
- DONE:
  - Control pins = 0. addr and data_out hold their values.
  - Pulse done of the granted port for 1 cycle, then return to IDLE.
- Latency: with ready already high, req sampled in cycle N gives gnt in N+1, done in N+3. A minimum of 1 idle cycle always separates transactions.
- Back-to-back: a requester holding req high after done is re-arbitrated in the next IDLE. With RR_EN = 1 the other port wins if it is requesting.
- A request dropped after gnt does not abort the transaction; done is still pulsed.
- Request inputs changing during ISSUE/DONE are ignored because the transaction uses latched values.
- Address arithmetic: none. Addresses pass through unchanged.

Optional Feature:
- Macro: RAM_ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit wait counter clears on entry to ISSUE and increments each ISSUE cycle while ready is low.
  - When the counter reaches MAX_WAIT, go to DONE with err = 1 in the done cycle; rdata is unchanged.
- Undefined: no counter; ISSUE waits forever; err is constant 0.

Decomposition:
- control_pins.v holds `RAM_READ_PIN, `RAM_WRITE_PIN and `RAM_READY_PIN.
- mobo_states.v gains `ARB_IDLE, `ARB_ISSUE and `ARB_DONE, with 2-bit encodings 0, 1, 2.
- Sub-module arb_pick: combinational port select from (req0, req1, last_grant, RR_EN), outputs valid and sel. It is natural to split out and reusable for a future third requester.

Test Plan:
- Single read: req0 = 1, we0 = 0, addr0 = 0x40, ready tied 1, data_in = 0xDEADBEEF -> gnt0 at +1, `RAM_READ_PIN high 1 cycle with addr = 0x40, done0 at +3, rdata = 0xDEADBEEF.
- Single write: req1 = 1, we1 = 1, addr1 = 0x100, wdata1 = 0x12345678, ready delayed 5 cycles -> `RAM_WRITE_PIN held 6 cycles, data_out = 0x12345678, done1 exactly once.
- Contention with RR_EN = 1: req0 and req1 both held high for 4 transactions -> grant order 0, 1, 0, 1. With RR_EN = 0 the order is 0, 0, 0, 0.
- Request drop: deassert req0 the cycle after gnt0 -> transaction completes and done0 still pulses.
- Reset mid-ISSUE: rst = 0 while `RAM_READ_PIN is high -> all outputs 0 asynchronously. After release, a new req0 is served normally.
- Timeout (RAM_ARB_TIMEOUT_EN, MAX_WAIT = 10): ready held 0 -> done0 and err pulse after 10 ISSUE cycles, and rdata is unchanged.
